// File: rtl/sprite_rom_pkg.sv
// Shared types and constants for the sprite/stage ROM arbiter.
// Requester numbering: background first, then the two player sprites.
package sprite_rom_pkg;

    function automatic int id_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    localparam int DEF_N_REQ  = 3;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 3;

    localparam int REQ_BG = 0;
    localparam int REQ_P1 = 1;
    localparam int REQ_P2 = 2;

    typedef logic [DEF_ADDR_W-1:0]          rom_addr_t;
    typedef logic [DEF_DATA_W-1:0]          pix_idx_t;
    typedef logic [id_width(DEF_N_REQ)-1:0] req_id_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request after rr_ptr.
// The scan index wraps by explicit compare so non-power-of-2 N_REQ works.
module rr_pick
    import sprite_rom_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             valid,
    output logic [ID_W-1:0]  id
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    logic [ID_W-1:0] scan_s;

    // Walk rr_ptr+1 .. rr_ptr+N_REQ, keeping the first hit.
    always_comb begin
        valid  = 1'b0;
        id     = {ID_W{1'b0}};
        scan_s = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (scan_s == LAST_ID) begin
                scan_s = {ID_W{1'b0}};
            end else begin
                scan_s = scan_s + {{(ID_W-1){1'b0}}, 1'b1};
            end
            if (!valid && req[scan_s]) begin
                valid = 1'b1;
                id    = scan_s;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous-read ROM port among N_REQ pixel requesters and
// routes each returned palette index back to its requester via a tag pipe.
module sprite_rom_arbiter
    import sprite_rom_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ROM_LAT = 1
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    output logic [N_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data
);

    localparam int              ID_W    = id_width(N_REQ);
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(N_REQ - 1);

    logic                pick_valid_s;
    logic [ID_W-1:0]     pick_id_s;
    logic [ADDR_W-1:0]   win_addr_s;
    logic [N_REQ-1:0]    gnt_s;
    logic [N_REQ-1:0]    rsp_onehot_s;

    logic [N_REQ-1:0]    gnt_r;
    logic [ADDR_W-1:0]   rom_addr_r;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [ROM_LAT:0]    tag_valid_r;
    logic [ID_W-1:0]     tag_id_r [0:ROM_LAT];
    logic [N_REQ-1:0]    rsp_valid_r;
    logic [DATA_W-1:0]   rsp_data_r;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_r),
        .valid  (pick_valid_s),
        .id     (pick_id_s)
    );

    // Winner's address slice and one-hot grant vector.
    always_comb begin
        win_addr_s = req_addr[pick_id_s*ADDR_W +: ADDR_W];
        gnt_s      = {N_REQ{1'b0}};
        if (pick_valid_s) begin
            gnt_s[pick_id_s] = 1'b1;
        end else begin
            gnt_s = {N_REQ{1'b0}};
        end
    end

    // Tail of the tag pipe decoded to a one-hot response owner.
    always_comb begin
        rsp_onehot_s = {N_REQ{1'b0}};
        if (tag_valid_r[ROM_LAT]) begin
            rsp_onehot_s[tag_id_r[ROM_LAT]] = 1'b1;
        end else begin
            rsp_onehot_s = {N_REQ{1'b0}};
        end
    end

    // Grant, ROM address, pointer, tag pipe and response registers.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_r       <= {N_REQ{1'b0}};
            rom_addr_r  <= {ADDR_W{1'b0}};
            rr_ptr_r    <= PTR_RST;
            tag_valid_r <= {(ROM_LAT+1){1'b0}};
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_id_r[k] <= {ID_W{1'b0}};
            end
            rsp_valid_r <= {N_REQ{1'b0}};
            rsp_data_r  <= {DATA_W{1'b0}};
        end else begin
            gnt_r <= gnt_s;
            if (pick_valid_s) begin
                rom_addr_r <= win_addr_s;
                rr_ptr_r   <= pick_id_s;
            end else begin
                rom_addr_r <= rom_addr_r;
                rr_ptr_r   <= rr_ptr_r;
            end
            // Idle cycles push a bubble so tags stay aligned with ROM latency.
            tag_valid_r[0] <= pick_valid_s;
            tag_id_r[0]    <= pick_id_s;
            for (int k = 1; k <= ROM_LAT; k++) begin
                tag_valid_r[k] <= tag_valid_r[k-1];
                tag_id_r[k]    <= tag_id_r[k-1];
            end
            rsp_valid_r <= rsp_onehot_s;
            if (tag_valid_r[ROM_LAT]) begin
                rsp_data_r <= rom_q;
            end else begin
                rsp_data_r <= rsp_data_r;
            end
        end
    end

    assign gnt       = gnt_r;
    assign rom_addr  = rom_addr_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: two instances (ROM latency 1 and 3) driven
// by identical stimulus and compared against a cycle-history reference model.
module tb_sprite_rom_arbiter;
    import sprite_rom_pkg::*;

    logic          clk;
    logic          reset_n;
    logic [2:0]    req;
    logic [44:0]   req_addr;
    logic [2:0]    gnt1, gnt3, rsp_valid1, rsp_valid3;
    logic [14:0]   rom_addr1, rom_addr3;
    logic [2:0]    rom_q1, rom_q3, rsp_data1, rsp_data3;
    logic [2:0]    rom3_p [0:2];

    sprite_rom_arbiter #(.N_REQ(3), .ADDR_W(15), .DATA_W(3), .ROM_LAT(1)) u_dut1 (
        .vga_clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
        .gnt(gnt1), .rom_addr(rom_addr1), .rom_q(rom_q1),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1));

    sprite_rom_arbiter #(.N_REQ(3), .ADDR_W(15), .DATA_W(3), .ROM_LAT(3)) u_dut3 (
        .vga_clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
        .gnt(gnt3), .rom_addr(rom_addr3), .rom_q(rom_q3),
        .rsp_valid(rsp_valid3), .rsp_data(rsp_data3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: addr[2:0] ^ 3'b101, read pipelines of depth 1 and 3.
    always @(posedge clk) begin
        rom_q1    <= rom_addr1[2:0] ^ 3'b101;
        rom3_p[0] <= rom_addr3[2:0] ^ 3'b101;
        rom3_p[1] <= rom3_p[0];
        rom3_p[2] <= rom3_p[1];
    end
    assign rom_q3 = rom3_p[2];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_rst = 0;
    int          m_ptr = 2;
    logic [2:0]  m_gnt = 3'b000;
    logic [14:0] m_addr = 15'h0000;
    logic        h_valid [0:4095];
    int          h_id    [0:4095];
    logic [14:0] h_addr  [0:4095];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic expect_rsp(input int lat, output logic [2:0] ev, output logic [2:0] ed);
        int g;
        g  = cyc - (lat + 1);
        ev = 3'b000;
        ed = 3'b000;
        if (g >= 0 && g > last_rst && h_valid[g]) begin
            ev = 3'(1 << h_id[g]);
            ed = h_addr[g][2:0] ^ 3'b101;
        end
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare #1 later.
    task automatic step(input logic rst_v, input logic [2:0] r,
                        input logic [14:0] a0, input logic [14:0] a1, input logic [14:0] a2);
        int w;
        logic [2:0] ev1, ed1, ev3, ed3;
        @(negedge clk);
        reset_n  = rst_v;
        req      = r;
        req_addr = {a2, a1, a0};
        @(posedge clk);
        cyc++;
        h_valid[cyc] = 1'b0;
        if (!rst_v) begin
            m_ptr    = 2;
            m_addr   = 15'h0000;
            m_gnt    = 3'b000;
            last_rst = cyc;
        end else begin
            w = -1;
            for (int k = 1; k <= 3; k++) begin
                if (w < 0 && r[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
            end
            if (w >= 0) begin
                m_gnt        = 3'(1 << w);
                m_ptr        = w;
                m_addr       = (w == 0) ? a0 : ((w == 1) ? a1 : a2);
                h_valid[cyc] = 1'b1;
                h_id[cyc]    = w;
                h_addr[cyc]  = m_addr;
            end else begin
                m_gnt = 3'b000;
            end
        end
        #1;
        expect_rsp(1, ev1, ed1);
        expect_rsp(3, ev3, ed3);
        chk("gnt_l1", 32'(gnt1), 32'(m_gnt));
        chk("gnt_l3", 32'(gnt3), 32'(m_gnt));
        chk("rom_addr_l1", 32'(rom_addr1), 32'(m_addr));
        chk("rom_addr_l3", 32'(rom_addr3), 32'(m_addr));
        chk("rsp_valid_l1", 32'(rsp_valid1), 32'(ev1));
        chk("rsp_valid_l3", 32'(rsp_valid3), 32'(ev3));
        if (!rst_v) begin
            chk("rsp_data_rst_l1", 32'(rsp_data1), 32'd0);
            chk("rsp_data_rst_l3", 32'(rsp_data3), 32'd0);
        end
        if (ev1 != 3'b000) chk("rsp_data_l1", 32'(rsp_data1), 32'(ed1));
        if (ev3 != 3'b000) chk("rsp_data_l3", 32'(rsp_data3), 32'(ed3));
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  gnt;
        logic [14:0] addr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int         cnt;
        logic       pend;
        logic       granted;
        logic [2:0] r;

        tbl[0]  = '{3'b111, 3'b001, 15'h0010};
        tbl[1]  = '{3'b111, 3'b010, 15'h0020};
        tbl[2]  = '{3'b111, 3'b100, 15'h0030};
        tbl[3]  = '{3'b111, 3'b001, 15'h0010};
        tbl[4]  = '{3'b011, 3'b010, 15'h0020};
        tbl[5]  = '{3'b011, 3'b001, 15'h0010};
        tbl[6]  = '{3'b111, 3'b010, 15'h0020};
        tbl[7]  = '{3'b100, 3'b100, 15'h0030};
        tbl[8]  = '{3'b000, 3'b000, 15'h0030};
        tbl[9]  = '{3'b101, 3'b001, 15'h0010};
        tbl[10] = '{3'b101, 3'b100, 15'h0030};
        tbl[11] = '{3'b110, 3'b010, 15'h0020};

        reset_n  = 1'b0;
        req      = 3'b111;
        req_addr = 45'd0;

        // Reset held with every requester active.
        step(1'b0, 3'b111, 15'h0010, 15'h0020, 15'h0030);
        step(1'b0, 3'b111, 15'h0010, 15'h0020, 15'h0030);
        chk("reset_gnt", 32'(gnt1 | gnt3), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid1 | rsp_valid3), 32'd0);

        // Round-robin table with fixed addresses.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, tbl[i].req, 15'h0010, 15'h0020, 15'h0030);
            chk("tbl_gnt", 32'(gnt1), 32'(tbl[i].gnt));
            chk("tbl_rom_addr", 32'(rom_addr1), 32'(tbl[i].addr));
        end

        // Single requester streaming: one grant every cycle.
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 3'b010, 15'h0100, 15'(15'h0200 + i), 15'h0300);
            if (gnt1 == 3'b010 && gnt3 == 3'b010) cnt++;
        end
        chk("solo_run", 32'(cnt), 32'd10);

        // Requester 2 cuts into a 0/1 stream.
        for (int i = 0; i < 3; i++) step(1'b1, 3'b011, 15'h0041, 15'h0052, 15'h0063);
        pend    = 1'b1;
        granted = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, {pend, 2'b11}, 15'h0041, 15'h0052, 15'h0063);
            if (gnt1[REQ_P2]) begin
                granted = 1'b1;
                pend    = 1'b0;
            end
        end
        chk("p2_granted_within_3", 32'(granted), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 3'b011, 15'h0041, 15'h0052, 15'h0063);

        // Reset with two reads in flight: no response may emerge.
        step(1'b1, 3'b111, 15'h0011, 15'h0022, 15'h0033);
        step(1'b1, 3'b111, 15'h0011, 15'h0022, 15'h0033);
        step(1'b0, 3'b111, 15'h0011, 15'h0022, 15'h0033);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 3'b000, 15'h0011, 15'h0022, 15'h0033);
            if ((rsp_valid1 | rsp_valid3) != 3'b000) cnt++;
        end
        chk("rst_no_rsp", 32'(cnt), 32'd0);
        step(1'b1, 3'b111, 15'h0011, 15'h0022, 15'h0033);
        chk("rst_first_gnt", 32'(gnt1), 32'h1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            r = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 63) != 0) ? 1'b1 : 1'b0, r,
                 15'($urandom), 15'($urandom), 15'($urandom));
        end
        for (int i = 0; i < 6; i++) step(1'b1, 3'b000, 15'h0000, 15'h0000, 15'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
